gfm_stream_extender: RTL

GFM_STREAM_EXTENDER -- requirements
Module: gfm_stream_extender

---
 rtl/gfm_pkg.sv | 26 ++
 rtl/base_onehot_enc.sv | 26 ++
 rtl/gfm_stream_extender.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gfm_pkg.sv
// -----------------------------------------------------------------------------
// gfm_pkg
// Shared definitions for the GFM stream extender slice.
//   - base_e      : 2-bit nucleotide code (A=00, C=01, G=10, T=11)
//   - BASE_LEN    : bits per packed base
//   - ONE_HOT_LEN : bits per one-hot encoded base
//   - state_e     : job sequencer states (IDLE accepts jobs, RUN emits beats)
// -----------------------------------------------------------------------------
package gfm_pkg;

    localparam int BASE_LEN    = 2;
    localparam int ONE_HOT_LEN = 4;

    typedef enum logic [BASE_LEN-1:0] {
        A = 2'b00,
        C = 2'b01,
        G = 2'b10,
        T = 2'b11
    } base_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/base_onehot_enc.sv
// -----------------------------------------------------------------------------
// base_onehot_enc
// Combinational expansion of one packed 2-bit base into a 4-bit one-hot code.
// Ports:
//   base   (in,  BASE_LEN)    : packed base code
//   onehot (out, ONE_HOT_LEN) : A->0001, C->0010, G->0100, T->1000
// -----------------------------------------------------------------------------
module base_onehot_enc
    import gfm_pkg::*;
(
    input  logic [BASE_LEN-1:0]    base,
    output logic [ONE_HOT_LEN-1:0] onehot
);

    always_comb begin
        onehot = '0;
        case (base_e'(base))
            A:       onehot = 4'b0001;
            C:       onehot = 4'b0010;
            G:       onehot = 4'b0100;
            T:       onehot = 4'b1000;
            default: onehot = '0;
        endcase
    end

endmodule

// File: rtl/gfm_stream_extender.sv
// -----------------------------------------------------------------------------
// gfm_stream_extender
// Accepts a job made of one packed DNA fragment plus a list of k-mer indices and
// streams it out as beats: for every valid index slot k, the whole fragment is
// replayed in PARTS beats of BASES_PER_BEAT one-hot bases, each tagged with the
// slot's index re-centred by OFFSET.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous abort of the job in progress (no done)
//   in_valid/in_ready : job handshake; in_ready is high only while IDLE
//   in_fragment       : 2*FRAG_BASES bits, base 0 at the LSBs
//   in_kmer_indices   : MAX_IDX slots of INDICE_LEN bits, slot 0 at the LSBs
//   in_idx_count      : number of valid slots, saturated to MAX_IDX
//   out_valid/out_ready : beat handshake
//   out_gfm           : one-hot bases of the current part, base j at [4j+:4]
//   out_index         : signed {0,idx}-OFFSET of the current slot
//   out_part          : part number of the current beat
//   out_first/out_last: first / final beat of the job
//   done              : one-cycle pulse after a job completes normally
// -----------------------------------------------------------------------------
module gfm_stream_extender
    import gfm_pkg::*;
#(
    parameter int FRAG_BASES     = 8,
    parameter int BASES_PER_BEAT = 2,
    parameter int KMER_SIZE      = 4,
    parameter int MAX_IDX        = 4,
    parameter int INDICE_LEN     = 3,
    localparam int PARTS         = FRAG_BASES / BASES_PER_BEAT,
    localparam int OUT_IDX_W     = INDICE_LEN + 1,
    localparam int CNT_W         = $clog2(MAX_IDX + 1),
    localparam int PART_W        = (PARTS > 1) ? $clog2(PARTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BASE_LEN*FRAG_BASES-1:0]  in_fragment,
    input  logic [MAX_IDX*INDICE_LEN-1:0]   in_kmer_indices,
    input  logic [CNT_W-1:0]                in_idx_count,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ONE_HOT_LEN*BASES_PER_BEAT-1:0] out_gfm,
    output logic [OUT_IDX_W-1:0]            out_index,
    output logic [PART_W-1:0]               out_part,
    output logic                            out_first,
    output logic                            out_last,
    output logic                            done
);

    localparam int OFFSET    = (FRAG_BASES - KMER_SIZE) >> 1;
    localparam int BEAT_BITS = BASE_LEN * BASES_PER_BEAT;

    localparam logic [OUT_IDX_W-1:0] OFFSET_V  = OUT_IDX_W'(OFFSET);
    localparam logic [PART_W-1:0]    LAST_PART = PART_W'(PARTS - 1);
    localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(MAX_IDX);

    // Reject parameter sets that would leave a partial final beat or a k-mer
    // longer than the fragment it is taken from.
    if (FRAG_BASES % BASES_PER_BEAT != 0) begin : g_bad_split
        $error("gfm_stream_extender: BASES_PER_BEAT must divide FRAG_BASES");
    end
    if (KMER_SIZE > FRAG_BASES) begin : g_bad_kmer
        $error("gfm_stream_extender: KMER_SIZE must not exceed FRAG_BASES");
    end

    state_e                         state_q, state_d;
    logic [PART_W-1:0]              p_q, p_d;
    logic [CNT_W-1:0]               k_q, k_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic                           done_q, done_d;

    logic [BASE_LEN*FRAG_BASES-1:0] frag_q;
    logic [MAX_IDX*INDICE_LEN-1:0]  idx_q;

    logic                           running;
    logic                           accept;
    logic                           is_last;
    logic [CNT_W-1:0]               count_sat;
    logic [BEAT_BITS-1:0]           beat_bases;
    logic [ONE_HOT_LEN*BASES_PER_BEAT-1:0] gfm_raw;
    logic [INDICE_LEN-1:0]          slot_idx;
    logic [OUT_IDX_W-1:0]           index_raw;

    // Counts above the slot capacity are clamped so the slot walk never reads
    // past the last latched index.
    always_comb begin
        count_sat = in_idx_count;
        if (in_idx_count > MAX_CNT) begin
            count_sat = MAX_CNT;
        end
    end

    assign running = (state_q == RUN);
    assign accept  = (state_q == IDLE) && in_valid;
    assign is_last = (k_q == (count_q - CNT_W'(1))) && (p_q == LAST_PART);

    // Control state: the only reset-affected registers. Everything the
    // outputs depend on that is not data goes back to zero here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            k_q     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Job payload is captured without reset: it is only observed while RUN,
    // and the outputs are forced to zero outside RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            frag_q <= in_fragment;
            idx_q  <= in_kmer_indices;
        end
    end

    // Sequencer. IDLE takes a job (an empty job finishes immediately with a
    // done pulse); RUN walks part p fastest, then slot k. A flush in RUN
    // beats a coincident handshake and suppresses done; flush in IDLE is
    // deliberately ignored so it cannot block an acceptance.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        k_d     = k_q;
        count_d = count_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    count_d = count_sat;
                    p_d     = '0;
                    k_d     = '0;
                    if (count_sat != '0) begin
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    p_d     = '0;
                    k_d     = '0;
                end else if (out_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        p_d     = '0;
                        k_d     = '0;
                    end else if (p_q == LAST_PART) begin
                        p_d = '0;
                        k_d = k_q + CNT_W'(1);
                    end else begin
                        p_d = p_q + PART_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bases belonging to the current part, handed to one encoder per base.
    assign beat_bases = frag_q[int'(p_q)*BEAT_BITS +: BEAT_BITS];

    for (genvar g = 0; g < BASES_PER_BEAT; g++) begin : g_enc
        base_onehot_enc u_enc (
            .base   (beat_bases[g*BASE_LEN +: BASE_LEN]),
            .onehot (gfm_raw[g*ONE_HOT_LEN +: ONE_HOT_LEN])
        );
    end

    // The index is zero-extended by one bit and re-centred; the subtraction
    // wraps modulo 2^OUT_IDX_W, giving a two's-complement result.
    assign slot_idx  = idx_q[int'(k_q)*INDICE_LEN +: INDICE_LEN];
    assign index_raw = {1'b0, slot_idx} - OFFSET_V;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = running;
    assign out_gfm   = running ? gfm_raw : '0;
    assign out_index = running ? index_raw : '0;
    assign out_part  = running ? p_q : '0;
    assign out_first = running && (k_q == '0) && (p_q == '0);
    assign out_last  = running && is_last;
    assign done      = done_q;

endmodule
